// File: rtl/pdp8_pkg.sv
// Shared PDP-8 peripheral definitions: reader FSM states, IOT function bit positions, device codes.
package pdp8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rdr_state_t;

  localparam int IOT_SKIP  = 0;
  localparam int IOT_READ  = 1;
  localparam int IOT_FETCH = 2;

  localparam logic [5:0] DEV_RDR = 6'o01;

endpackage

// File: rtl/rdr_uart_rx.sv
// 8N1 serial receiver for the tape reader: input synchroniser, oversampled framing FSM and shift register.
module rdr_uart_rx
  import pdp8_pkg::*;
#(
  parameter int OVERSAMPLE  = 7,
  parameter int SAMPLE_PT   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       tick,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       idle
);

  localparam int CW = $clog2(OVERSAMPLE);

  logic [SYNC_STAGES-1:0] sync_reg;
  rdr_state_t             state_reg;
  logic [CW-1:0]          cnt_reg;
  logic [2:0]             bit_reg;
  logic [7:0]             shift_reg;
  logic                   valid_reg;
  logic                   rx_s;

  assign rx_s       = sync_reg[SYNC_STAGES-1];
  assign data_byte  = shift_reg;
  assign byte_valid = valid_reg;
  assign idle       = (state_reg == IDLE);

  // Sync flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '1;
    end else if (clear) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
    end else if (clear) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (tick) begin
        case (state_reg)
          IDLE: begin
            if (!rx_s) begin
              state_reg <= START;
              cnt_reg   <= '0;
            end
          end
          START: begin
            if (cnt_reg == CW'(SAMPLE_PT - 1)) begin
              cnt_reg   <= '0;
              bit_reg   <= '0;
              state_reg <= rx_s ? IDLE : DATA;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          DATA: begin
            if (cnt_reg == CW'(OVERSAMPLE - 1)) begin
              cnt_reg   <= '0;
              shift_reg <= {rx_s, shift_reg[7:1]};
              bit_reg   <= bit_reg + 1'b1;
              if (bit_reg == 3'd7) begin
                state_reg <= STOP;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          STOP: begin
            // A low stop bit is a framing error: the byte is silently discarded.
            if (cnt_reg == CW'(OVERSAMPLE - 1)) begin
              cnt_reg   <= '0;
              valid_reg <= rx_s;
              state_reg <= IDLE;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/iot601x_tape_reader.sv
// High-speed paper-tape reader, IOT device 01: buffer/flag/enable state and IOT phase decode.
// Optional macro RDR_FLOWCTL_EN: rts flow control and overrun drop of unrequested frames.
module iot601x_tape_reader
  import pdp8_pkg::*;
#(
  parameter int OVERSAMPLE  = 7,
  parameter int SAMPLE_PT   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clear,
  input  logic        baudX7,
  input  logic        rxRdr,
  input  logic        EN,
  input  logic [2:0]  IR,
  input  logic [5:0]  ck,
  input  logic [5:0]  stb,
  output logic        done,
  output logic        pc_ck,
  output logic        rot2ac,
  output logic        ac_ck,
  output logic [11:0] ACRDR,
  output logic        irq,
  output logic        rts
);

  logic [7:0] buffer_reg;
  logic       flag_reg;
  logic       ie_reg;
  logic       armed_reg;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_idle;
  logic       load;
  logic       iot_rpe;
  logic       read_phase;
  logic       rrb_clr;
  logic       rfc;
  logic       unused_phases;

  rdr_uart_rx #(
    .OVERSAMPLE  (OVERSAMPLE),
    .SAMPLE_PT   (SAMPLE_PT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk        (CLK),
    .rst        (RESET),
    .clear      (clear),
    .tick       (baudX7),
    .rx         (rxRdr),
    .data_byte  (rx_byte),
    .byte_valid (rx_valid),
    .idle       (rx_idle)
  );

  assign iot_rpe    = EN & (IR == 3'b000) & stb[0];
  assign read_phase = EN & IR[IOT_READ] & ck[1];
  assign rrb_clr    = EN & IR[IOT_READ] & stb[1];
  assign rfc        = EN & IR[IOT_FETCH] & stb[2];

  assign pc_ck  = EN & IR[IOT_SKIP] & stb[0] & flag_reg;
  assign rot2ac = read_phase;
  assign ac_ck  = rrb_clr;
  assign ACRDR  = read_phase ? {4'b0000, buffer_reg} : 12'o0000;
  assign done   = EN & stb[3];
  assign irq    = flag_reg & ie_reg;

  assign unused_phases = ^{ck[5:2], ck[0], stb[5:4]};

`ifdef RDR_FLOWCTL_EN
  assign load = rx_valid & armed_reg;
  assign rts  = armed_reg & rx_idle;
`else
  logic unused_flow;
  assign load        = rx_valid;
  assign rts         = 1'b1;
  assign unused_flow = armed_reg ^ rx_idle;
`endif

  // Load is applied last so a byte arriving with an RRB/RFC clear leaves the flag set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      buffer_reg <= 8'h00;
      flag_reg   <= 1'b0;
      ie_reg     <= 1'b1;
      armed_reg  <= 1'b1;
    end else if (clear) begin
      buffer_reg <= 8'h00;
      flag_reg   <= 1'b0;
      ie_reg     <= 1'b1;
      armed_reg  <= 1'b1;
    end else begin
      if (iot_rpe) begin
        ie_reg <= 1'b1;
      end
      if (rrb_clr || rfc) begin
        flag_reg <= 1'b0;
      end
      if (rfc) begin
        armed_reg <= 1'b1;
      end
      if (load) begin
        buffer_reg <= rx_byte;
        flag_reg   <= 1'b1;
        armed_reg  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iot601x_tape_reader.sv
// Scoreboard bench for the tape reader: IOT stimulus queues expected skip/read/done events, a monitor pops them.
module tb_iot601x_tape_reader;

`ifdef RDR_FLOWCTL_EN
  localparam bit FLOW = 1'b1;
`else
  localparam bit FLOW = 1'b0;
`endif

  localparam int K_SKIP = 0;
  localparam int K_AC   = 1;
  localparam int K_DONE = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        clear = 1'b0;
  logic        baudX7 = 1'b0;
  logic        rxRdr = 1'b1;
  logic        EN = 1'b0;
  logic [2:0]  IR = 3'b000;
  logic [5:0]  ck = 6'b0;
  logic [5:0]  stb = 6'b0;
  logic        done, pc_ck, rot2ac, ac_ck, irq, rts;
  logic [11:0] ACRDR;

  typedef struct {
    int          kind;
    logic [12:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   events_seen = 0;
  int   bcnt = 0;

  iot601x_tape_reader dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (clear),
    .baudX7 (baudX7),
    .rxRdr  (rxRdr),
    .EN     (EN),
    .IR     (IR),
    .ck     (ck),
    .stb    (stb),
    .done   (done),
    .pc_ck  (pc_ck),
    .rot2ac (rot2ac),
    .ac_ck  (ac_ck),
    .ACRDR  (ACRDR),
    .irq    (irq),
    .rts    (rts)
  );

  always #5 CLK = ~CLK;

  // One baudX7 pulse every 4 clocks: a bit lasts 28 clocks.
  always @(posedge CLK) begin
    bcnt   <= (bcnt == 3) ? 0 : bcnt + 1;
    baudX7 <= (bcnt == 3);
  end

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic mon_event(input int kind, input logic [12:0] act);
    exp_t e;
    events_seen++;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event kind=%0d actual=%h required=none", kind, act);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        checks++;
        failures++;
        $display("FAIL event_order actual_kind=%0d required_kind=%0d", kind, e.kind);
      end else begin
        chk(kind == K_SKIP ? "skip" : (kind == K_AC ? "ac_read" : "done_status"), act, e.val);
      end
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (pc_ck) mon_event(K_SKIP, 13'd0);
    if (ac_ck) mon_event(K_AC, {rot2ac, ACRDR});
    if (done)  mon_event(K_DONE, {11'd0, rts, irq});
  end

  task automatic exp_skip();
    exp_q.push_back('{kind: K_SKIP, val: 13'd0});
  endtask

  task automatic exp_ac(input logic [11:0] v);
    exp_q.push_back('{kind: K_AC, val: {1'b1, v}});
  endtask

  task automatic exp_done(input logic r, input logic i);
    exp_q.push_back('{kind: K_DONE, val: {11'd0, r, i}});
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    rxRdr = 1'b0;
    wait_clk(28);
    for (int i = 0; i < 8; i++) begin
      rxRdr = d[i];
      wait_clk(28);
    end
    if (stop_ok) begin
      rxRdr = 1'b1;
      wait_clk(28);
    end else begin
      rxRdr = 1'b0;
      wait_clk(22);
      rxRdr = 1'b1;
    end
    wait_clk(40);
  endtask

  task automatic iot(input logic [2:0] ir, input logic en);
    EN = en;
    IR = ir;
    for (int p = 0; p < 6; p++) begin
      ck = 6'(1 << p);
      wait_clk(1);
      stb = 6'(1 << p);
      wait_clk(1);
      stb = 6'b0;
    end
    ck = 6'b0;
    EN = 1'b0;
    IR = 3'b000;
    wait_clk(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ev;
    wait_clk(5);
    chk("reset_iot_out", {9'd0, done, pc_ck, rot2ac, ac_ck}, 13'd0);
    chk("reset_acrdr", {1'b0, ACRDR}, 13'd0);
    chk("reset_irq", 13'(irq), 13'd0);
    chk("reset_rts", 13'(rts), 13'd1);
    RESET = 1'b0;
    wait_clk(5);

    // 0x8D then RSF: skip at stb1, done with irq set
    send_frame(8'h8D, 1'b1);
    chk("rx_8d_irq", 13'(irq), 13'd1);
    chk("rx_8d_rts", 13'(rts), FLOW ? 13'd0 : 13'd1);
    exp_skip();
    exp_done(!FLOW, 1'b1);
    iot(3'b001, 1'b1);

    // 6016 drains 0x8D and re-arms
    exp_ac(12'h08D);
    exp_done(1'b1, 1'b0);
    iot(3'b110, 1'b1);
    chk("rfc_irq_clear", 13'(irq), 13'd0);

    // RSF with flag clear: no skip
    exp_done(1'b1, 1'b0);
    iot(3'b001, 1'b1);

    // 0x41 then 6016
    send_frame(8'h41, 1'b1);
    chk("rx_41_rts", 13'(rts), FLOW ? 13'd0 : 13'd1);
    exp_ac(12'o0101);
    exp_done(1'b1, 1'b0);
    iot(3'b110, 1'b1);
    chk("rts_after_rfc", 13'(rts), 13'd1);

    // two-tick glitch is rejected
    rxRdr = 1'b0;
    wait_clk(8);
    rxRdr = 1'b1;
    wait_clk(60);
    chk("glitch_irq", 13'(irq), 13'd0);
    chk("glitch_idle_rts", 13'(rts), 13'd1);

    // framing error leaves buffer untouched
    send_frame(8'h33, 1'b0);
    chk("frame_err_irq", 13'(irq), 13'd0);
    exp_ac(12'h041);
    exp_done(1'b1, 1'b0);
    iot(3'b010, 1'b1);

    // second byte without RFC
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk("overrun_irq", 13'(irq), 13'd1);
    exp_ac(FLOW ? 12'h011 : 12'h022);
    exp_done(1'b1, 1'b0);
    iot(3'b110, 1'b1);

    // disabled IOT produces nothing and leaves flag set
    send_frame(8'h5A, 1'b1);
    ev = events_seen;
    iot(3'b111, 1'b0);
    chk("en_low_events", 13'(events_seen - ev), 13'd0);
    chk("en_low_irq", 13'(irq), 13'd1);
    exp_done(!FLOW, 1'b1);
    iot(3'b000, 1'b1);

    // clear in the middle of the data bits of 0x3C
    rxRdr = 1'b0;
    wait_clk(28);
    for (int i = 0; i < 4; i++) begin
      rxRdr = (i == 2 || i == 3);
      wait_clk(28);
    end
    clear = 1'b1;
    wait_clk(1);
    clear = 1'b0;
    rxRdr = 1'b1;
    wait_clk(300);
    chk("clear_irq", 13'(irq), 13'd0);
    chk("clear_rts", 13'(rts), 13'd1);
    exp_ac(12'h000);
    exp_done(1'b1, 1'b0);
    iot(3'b010, 1'b1);

    send_frame(8'h55, 1'b1);
    chk("rx_55_irq", 13'(irq), 13'd1);
    exp_ac(12'h055);
    exp_done(1'b1, 1'b0);
    iot(3'b110, 1'b1);

    wait_clk(10);
    chk("queue_empty", 13'(exp_q.size()), 13'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
